// File: rtl/program_counter_rs_pkg.sv
// Shared operation encoding and sizing helper for the program counter with return-address stack.
`default_nettype none

package program_counter_rs_pkg;

    // Decoded per-edge operation, listed in priority order after reset.
    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_RET  = 3'd1,
        OP_CALL = 3'd2,
        OP_JMP  = 3'd3,
        OP_BR   = 3'd4,
        OP_INC  = 3'd5
    } pc_op_e;

    function automatic int stack_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/program_counter_rs_if.sv
// Control and status bundle between the control unit (master) and the program counter (slave).
`default_nettype none

interface program_counter_rs_if
    import program_counter_rs_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int STACK_DEPTH = 8
);
    localparam int CW = stack_count_width(STACK_DEPTH);

    logic                  stall;
    logic                  jump_enable;
    logic [ADDR_WIDTH-1:0] jump_address;
    logic                  branch_enable;
    logic [ADDR_WIDTH-1:0] branch_offset;
    logic                  call_enable;
    logic                  return_enable;
    logic [ADDR_WIDTH-1:0] counter_reg;
    logic [CW-1:0]         stack_count;
    logic                  stack_empty;
    logic                  stack_full;
    logic                  stack_overflow;
    logic                  stack_underflow;

    modport master (
        output stall, jump_enable, jump_address, branch_enable, branch_offset,
               call_enable, return_enable,
        input  counter_reg, stack_count, stack_empty, stack_full,
               stack_overflow, stack_underflow
    );

    modport slave (
        input  stall, jump_enable, jump_address, branch_enable, branch_offset,
               call_enable, return_enable,
        output counter_reg, stack_count, stack_empty, stack_full,
               stack_overflow, stack_underflow
    );

endinterface

`default_nettype wire

// File: rtl/program_counter_rs_return_stack.sv
// Parametrised LIFO of return addresses; only the occupancy pointer is reset.
`default_nettype none

module program_counter_rs_return_stack
    import program_counter_rs_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  wire logic                                  clk,
    input  wire logic                                  reset,
    input  wire logic                                  push,
    input  wire logic                                  pop,
    input  wire logic [DATA_WIDTH-1:0]                 push_data,
    output logic      [DATA_WIDTH-1:0]                 top_data,
    output logic      [stack_count_width(DEPTH)-1:0]   count,
    output logic                                       full,
    output logic                                       empty
);
    localparam int CW = stack_count_width(DEPTH);
    localparam int IW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         top_idx;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign wr_idx  = IW'(count);
    assign top_idx = IW'(count - CW'(1));
    assign top_data = mem[top_idx];

    // A pop takes precedence if both are requested; the caller never does this.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (pop_ok) begin
            count <= count - CW'(1);
        end else if (push_ok) begin
            count <= count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !pop_ok) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/program_counter_rs.sv
// Fetch-stage program counter with increment, jump, relative branch, call/return stack and stall.
`default_nettype none

module program_counter_rs
    import program_counter_rs_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    STACK_DEPTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  wire logic           clk,
    input  wire logic           reset,
    program_counter_rs_if.slave bus
);
    localparam int CW = stack_count_width(STACK_DEPTH);

    pc_op_e                op;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] top_data;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  overflow;
    logic                  underflow;

    always_comb begin
        op = OP_INC;
        if (bus.stall)              op = OP_HOLD;
        else if (bus.return_enable) op = OP_RET;
        else if (bus.call_enable)   op = OP_CALL;
        else if (bus.jump_enable)   op = OP_JMP;
        else if (bus.branch_enable) op = OP_BR;
    end

    assign pc_inc = pc + ADDR_WIDTH'(1);
    assign push   = (op == OP_CALL) && !full;
    assign pop    = (op == OP_RET) && !empty;

    program_counter_rs_return_stack #(
        .DATA_WIDTH (ADDR_WIDTH),
        .DEPTH      (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (top_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // A rejected call or return still advances the PC so fetch never stalls on an error.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_VECTOR;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (op)
                OP_HOLD: pc <= pc;
                OP_RET: begin
                    if (empty) begin
                        pc        <= pc_inc;
                        underflow <= 1'b1;
                    end else begin
                        pc <= top_data;
                    end
                end
                OP_CALL: begin
                    if (full) begin
                        pc       <= pc_inc;
                        overflow <= 1'b1;
                    end else begin
                        pc <= bus.jump_address;
                    end
                end
                OP_JMP:  pc <= bus.jump_address;
                OP_BR:   pc <= pc + bus.branch_offset;
                OP_INC:  pc <= pc_inc;
                default: pc <= pc;
            endcase
        end
    end

    assign bus.counter_reg     = pc;
    assign bus.stack_count     = count;
    assign bus.stack_empty     = empty;
    assign bus.stack_full      = full;
    assign bus.stack_overflow  = overflow;
    assign bus.stack_underflow = underflow;

endmodule

`default_nettype wire
